memory_ctrl: RTL and testbench

//   Upstream driver for the single-port memory (clk, wr, rd, addr, bidirectional data).

---
 rtl/memory_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_memory_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// memory_ctrl
//   Upstream driver for a single-port memory with a bidirectional data bus.
//   Requests arrive on a valid/ready port, are buffered in a QDEPTH-entry FIFO
//   and are issued one access per cycle. A single idle TURN cycle separates
//   accesses whose direction differs, so the bus never has two drivers.
//   Read data comes back on a one-cycle rsp_valid pulse.
//
// Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both high. req_ready is !full, derived from the registered
//   occupancy only, so a pop in the same cycle never re-opens a full queue.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_wr, req_addr,     request: 1 = write / 0 = read, address, write data
//   req_wdata
//   rsp_valid, rsp_rdata  read response pulse and held read data
//   mem_wr, mem_rd,       registered memory strobes and address
//   mem_addr
//   mem_data              tristate bus, driven only while in WRITE
//   dbg_state             current FSM state (0 IDLE, 1 WRITE, 2 READ, 3 TURN)
//   wr_count, rd_count    saturating access counters, present only when
//                         MEM_CTRL_STATS_EN is defined
module memory_ctrl #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data,
    output logic [1:0]        dbg_state
`ifdef MEM_CTRL_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    // Queue storage
    logic              q_wr_q   [QDEPTH];
    logic [AWIDTH-1:0] q_addr_q [QDEPTH];
    logic [DWIDTH-1:0] q_data_q [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // FSM and registered memory-side outputs
    logic [1:0]        state_q, state_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic push, pop, empty, head_wr, start;

    assign req_ready = (count_q != CW'(QDEPTH));
    assign empty     = (count_q == '0);
    assign push      = req_valid && req_ready;
    assign head_wr   = q_wr_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        mem_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        start       = 1'b0;

        // The read cycle closes on this edge: capture the bus and pulse next cycle.
        if (state_q == S_READ) begin
            rsp_rdata_d = mem_data;
            rsp_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!empty) start = 1'b1;
            end
            S_WRITE, S_READ: begin
                if (empty)
                    state_d = S_IDLE;
                else if (head_wr == (state_q == S_WRITE))
                    start = 1'b1;
                else
                    state_d = S_TURN;   // head stays queued through the turnaround
            end
            default: begin  // S_TURN
                if (!empty) start = 1'b1;
                else        state_d = S_IDLE;
            end
        endcase

        pop = start;
        if (start) begin
            state_d    = head_wr ? S_WRITE : S_READ;
            mem_wr_d   = head_wr;
            mem_rd_d   = !head_wr;
            mem_addr_d = q_addr_q[rd_ptr_q];
            wdata_d    = q_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            q_wr_q[wr_ptr_q]   <= req_wr;
            q_addr_q[wr_ptr_q] <= req_addr;
            q_data_q[wr_ptr_q] <= req_wdata;
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_state = state_q;
    assign mem_data  = (state_q == S_WRITE) ? wdata_q : {DWIDTH{1'bz}};

`ifdef MEM_CTRL_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (state_q == S_WRITE && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        if (state_q == S_READ  && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_memory_ctrl.sv
// tb_memory_ctrl
//   Bench for memory_ctrl with a behavioural single-port memory on the bus.
//   Read responses are matched against an expected-data queue filled when
//   each read request is accepted.
module tb_memory_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_wr;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_wr, mem_rd;
    logic [4:0] mem_addr;
    wire  [7:0] mem_data;
    logic [1:0] dbg_state;
`ifdef MEM_CTRL_STATS_EN
    logic [15:0] wr_count, rd_count;
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    memory_ctrl #(.AWIDTH(5), .DWIDTH(8), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .dbg_state(dbg_state)
`ifdef MEM_CTRL_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count)
`endif
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [32];
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;
    assign mem_data = mem_rd ? mem[mem_addr] : 8'bz;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] model [32];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int n_turn = 0, n_write = 0, n_read = 0;
    int first_w = -1, last_w = -1, first_r = -1, last_r = -1;
    bit saw_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            case (dbg_state)
                ST_TURN:  n_turn++;
                ST_WRITE: begin n_write++; if (first_w < 0) first_w = cyc; last_w = cyc; end
                ST_READ:  begin n_read++;  if (first_r < 0) first_r = cyc; last_r = cyc; end
                default: ;
            endcase
            if (req_valid && !req_ready) saw_full = 1'b1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_rdata %0h with nothing expected", rsp_rdata);
                end else begin
                    check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the request transferred.
    task automatic send(input bit wr, input logic [4:0] a, input logic [7:0] d,
                        input bit has_exp = 1'b0, input logic [7:0] exp = 8'h00);
        int t = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: req_ready stayed 0 expected 1");
        end
        if (wr) model[a] = d;
        else    exp_q.push_back(has_exp ? exp : model[a]);
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        req_valid = 1'b0;
        while (!(exp_q.size() == 0 && dbg_state == ST_IDLE) && t < 300) begin
            @(negedge clk); t++;
        end
        if (t >= 300) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding expected 0", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        bit         wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t tbl [12];

    initial begin
        int t0, w0, r0, bad;
        tbl[0]  = '{1'b1, 5'd10, 8'h3C, 8'h00};
        tbl[1]  = '{1'b1, 5'd11, 8'hC3, 8'h00};
        tbl[2]  = '{1'b0, 5'd10, 8'h00, 8'h3C};
        tbl[3]  = '{1'b0, 5'd11, 8'h00, 8'hC3};
        tbl[4]  = '{1'b1, 5'd0,  8'hFF, 8'h00};
        tbl[5]  = '{1'b0, 5'd0,  8'h00, 8'hFF};
        tbl[6]  = '{1'b1, 5'd10, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 5'd10, 8'h00, 8'h00};
        tbl[8]  = '{1'b0, 5'd11, 8'h00, 8'hC3};
        tbl[9]  = '{1'b1, 5'd31, 8'h80, 8'h00};
        tbl[10] = '{1'b0, 5'd31, 8'h00, 8'h80};
        tbl[11] = '{1'b0, 5'd0,  8'h00, 8'hFF};

        for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; model[i] = 8'h00; end
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;

        // 1. reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_wr",    {31'd0, mem_wr},    32'd0);
        check("rst_mem_rd",    {31'd0, mem_rd},    32'd0);
        check("rst_mem_addr",  {27'd0, mem_addr},  32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_state",     {30'd0, dbg_state}, {30'd0, ST_IDLE});
        rst = 1'b0;
        @(negedge clk);

        // 2. write then read addr 31: one turnaround
        t0 = n_turn;
        send(1'b1, 5'd31, 8'h00);
        send(1'b0, 5'd31, 8'h00, 1'b1, 8'h00);
        drain();
        check("wr_rd_turns", n_turn - t0, 32'd1);

        // latency from an empty, idle controller
        send(1'b1, 5'd31, 8'h5A);
        drain();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'd31;
        exp_q.push_back(8'h5A);
        @(negedge clk);   // cycle 1
        req_valid = 1'b0;
        check("lat_c1_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("lat_c1_mem_rd", {31'd0, mem_rd}, 32'd0);
        @(negedge clk);   // cycle 2
        check("lat_c2_mem_rd", {31'd0, mem_rd}, 32'd1);
        check("lat_c2_addr", {27'd0, mem_addr}, 32'd31);
        check("lat_c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);   // cycle 3
        check("lat_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        check("lat_c4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("lat_c4_rdata_hold", {24'd0, rsp_rdata}, 32'h5A);
        drain();

        // 3. fill all 32 addresses, then read them back, inputs held valid
        w0 = n_write; r0 = n_read; first_w = -1; first_r = -1; saw_full = 1'b0;
        for (int i = 0; i < 32; i++) send(1'b1, 5'(31 - i), 8'(i));
        for (int i = 0; i < 32; i++) send(1'b0, 5'(31 - i), 8'h00, 1'b1, 8'(i));
        drain();
        check("fill_writes", n_write - w0, 32'd32);
        check("fill_write_span", last_w - first_w + 1, 32'd32);
        check("fill_reads", n_read - r0, 32'd32);
        check("fill_read_span", last_r - first_r + 1, 32'd32);
        check("fill_saw_full", {31'd0, saw_full}, 32'd1);

        // 4. alternating W(3,A5)/R(3) x4: turnaround before every op after the first
        t0 = n_turn;
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 5'd3, 8'hA5);
            send(1'b0, 5'd3, 8'h00, 1'b1, 8'hA5);
        end
        drain();
        check("alt_turns", n_turn - t0, 32'd7);

        // table-driven vectors
        for (int i = 0; i < 12; i++)
            send(tbl[i].wr, tbl[i].addr, tbl[i].wdata, !tbl[i].wr, tbl[i].exp_rdata);
        drain();

        // random mix checked against the model
        for (int i = 0; i < 40; i++)
            send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        drain();

        // 5. reset during a READ cycle with requests queued
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'd7;
        @(negedge clk);
        req_wr = 1'b1; req_addr = 5'd8; req_wdata = 8'h11;
        @(negedge clk);
        req_addr = 5'd9; req_wdata = 8'h22;
        check("rstmid_in_read", {30'd0, dbg_state}, {30'd0, ST_READ});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        check("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstmid_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstmid_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_wr || mem_rd || rsp_valid) bad++;
        end
        check("rstmid_queue_discarded", bad, 32'd0);

`ifdef MEM_CTRL_STATS_EN
        // 6. access counters
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) send(1'b1, 5'(i), 8'(i + 1));
        for (int i = 0; i < 3; i++) send(1'b0, 5'(i), 8'h00);
        drain();
        check("stats_wr_count", {16'd0, wr_count}, 32'd5);
        check("stats_rd_count", {16'd0, rd_count}, 32'd3);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("stats_wr_clear", {16'd0, wr_count}, 32'd0);
        check("stats_rd_clear", {16'd0, rd_count}, 32'd0);
`endif

        check("final_exp_q_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
